// File: rtl/gf_digit_serial_mult_ctrl.sv
// -----------------------------------------------------------------------------
// gf_digit_serial_mult_ctrl
//
// Sequencer for a digit-serial GF(2^M) multiplier. One operand pair is
// accepted in IDLE. Operand B is then walked MSB-first in 2-bit digits, one
// digit per clock in RUN. Each step multiplies the accumulator by x^2, folds
// in the carry-less product A*digit, and reduces modulo x^M + POLY. The
// finished product is presented in DONE until the consumer takes it.
//
// Parameters
//   M     field degree (even, >= 4); an operation takes M/2 RUN cycles
//   POLY  low M bits of the irreducible field polynomial (x^M implied)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  block can accept operands (IDLE)
//   a          in   M  operand A, captured on the accept edge
//   b          in   M  operand B, captured on the accept edge
//   out_valid  out  1  y holds a finished product (DONE)
//   out_ready  in   1  consumer accepts y
//   y          out  M  A*B mod P, held until the next product completes
//   abort      in   1  (only with GF_ABORT_EN) drop the current operation
//   busy       out  1  high while digits are being processed (RUN)
//
// Configuration
//   GF_ABORT_EN  when defined, adds the abort input. abort in RUN or DONE
//                returns to IDLE on the next edge without touching y, and
//                wins over out_ready and over the final digit step. abort in
//                IDLE blocks acceptance for that cycle.
// -----------------------------------------------------------------------------
module gf_digit_serial_mult_ctrl #(
  parameter int           M    = 8,
  parameter logic [M-1:0] POLY = 8'h1B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] y,
`ifdef GF_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam int DIGITS = M / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [M-1:0]   a_r;
  logic [M-1:0]   b_r;
  logic [M-1:0]   acc_r;
  logic [CW-1:0]  cnt_r;
  logic [M-1:0]   y_r;
  logic [M-1:0]   b_shift_s;
  logic [1:0]     digit_s;
  logic [M-1:0]   step_s;
  logic           abort_s;
  logic           accept_s;
  logic           in_ready_s;
  logic           out_valid_s;
  logic           busy_s;

  // One digit step: acc*x^2 ^ opa*dig, reduced back to M bits.
  // The x^(M+1) term is folded first because its reduction (POLY<<1) can
  // set bit M again; the x^M fold then sees the updated bit.
  function automatic logic [M-1:0] gf_digit_step(
    input logic [M-1:0] acc,
    input logic [M-1:0] opa,
    input logic [1:0]   dig
  );
    logic [M+1:0] t;
    t = {acc, 2'b00};
    t = t ^ ({(M+2){dig[0]}} & {2'b00, opa});
    t = t ^ ({(M+2){dig[1]}} & {1'b0, opa, 1'b0});
    t[M:1]   = t[M:1]   ^ (POLY & {M{t[M+1]}});
    t[M-1:0] = t[M-1:0] ^ (POLY & {M{t[M]}});
    return t[M-1:0];
  endfunction

`ifdef GF_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Digit cnt of B sits at bits [2*cnt+1 : 2*cnt].
  assign b_shift_s = b_r >> {cnt_r, 1'b0};
  assign digit_s   = b_shift_s[1:0];
  assign step_s    = gf_digit_step(acc_r, a_r, digit_s);
  assign accept_s  = in_valid & in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks both completion and hand-off.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort_s || out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = ~abort_s;
      end
      ST_RUN: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Operand capture, digit accumulation and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {M{1'b0}};
      b_r   <= {M{1'b0}};
      acc_r <= {M{1'b0}};
      cnt_r <= {CW{1'b0}};
      y_r   <= {M{1'b0}};
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      acc_r <= {M{1'b0}};
      cnt_r <= CNT_LAST;
    end else if ((state_r == ST_RUN) && !abort_s) begin
      acc_r <= step_s;
      if (cnt_r == {CW{1'b0}}) begin
        y_r <= step_s;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign y         = y_r;

endmodule

// File: tb/tb_gf_digit_serial_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gf_digit_serial_mult_ctrl
//
// Self-checking bench for gf_digit_serial_mult_ctrl (M=8, AES polynomial).
// Expected products come either from known constants or from a bit-serial
// schoolbook multiply followed by long-division reduction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf_digit_serial_mult_ctrl;

  localparam int           M    = 8;
  localparam logic [M-1:0] POLY = 8'h1B;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [M-1:0] a         = '0;
  logic [M-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [M-1:0] y;
`ifdef GF_ABORT_EN
  logic         abort     = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gf_digit_serial_mult_ctrl #(.M(M), .POLY(POLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
`ifdef GF_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  // Schoolbook carry-less product, then reduce from the top degree down.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] z);
    logic [2*M-1:0] p;
    logic [2*M-1:0] xw;
    logic [2*M-1:0] fw;
    p  = '0;
    xw = {{M{1'b0}}, x};
    for (int i = 0; i < M; i++) begin
      if (z[i]) p = p ^ (xw << i);
    end
    fw = {{(M-1){1'b0}}, 1'b1, POLY};
    for (int d = 2*M-2; d >= M; d--) begin
      if (p[d]) p = p ^ (fw << (d - M));
    end
    return p[M-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, time the RUN phase, optionally stall the
  // consumer for 'hold' cycles while offering new operands, then hand off.
  task automatic run_op(input string tag, input logic [M-1:0] av, input logic [M-1:0] bv,
                        input logic [M-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = M'($urandom);
    b = M'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(M/2));
    check({tag, "_y"}, 32'(y), 32'(exp));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick();
      check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_y"}, 32'(y), 32'(exp));
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_y_keep"}, 32'(y), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] qa [3];
    logic [M-1:0] qb [3];
    logic [M-1:0] qy [3];
    logic [M-1:0] ra;
    logic [M-1:0] rb;
    int acc_n;
    int res_n;
    int last_t;
    int cyc;
    logic busy_q;
    logic ov_q;

    // Reset values while rst_n is held low.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed products from known field values.
    run_op("p57x83", 8'h57, 8'h83, 8'hC1, 0);
    run_op("p57x13_hold", 8'h57, 8'h13, 8'hFE, 10);
    run_op("p00xFF", 8'h00, 8'hFF, 8'h00, 0);
    run_op("pA5x01", 8'hA5, 8'h01, 8'hA5, 0);
    run_op("pFFxFF", 8'hFF, 8'hFF, 8'h13, 1);

    // Randomized operands against the reference multiply.
    for (int k = 0; k < 24; k++) begin
      ra = M'($urandom);
      rb = M'($urandom);
      if (k == 0) ra = 8'h00;
      if (k == 1) rb = 8'h01;
      run_op("rand", ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)));
    end

    // Back-to-back: in_valid and out_ready held high across three operations.
    qa[0] = 8'h02; qb[0] = 8'h87; qy[0] = 8'h15;
    qa[1] = 8'h57; qb[1] = 8'h83; qy[1] = 8'hC1;
    qa[2] = 8'h53; qb[2] = 8'hCA; qy[2] = 8'h01;
    acc_n = 0; res_n = 0; last_t = 0; cyc = 0; busy_q = 1'b0; ov_q = 1'b0;
    a = qa[0];
    b = qb[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (res_n < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (busy && !busy_q) begin
        acc_n++;
        if (acc_n < 3) begin
          a = qa[acc_n];
          b = qb[acc_n];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && !ov_q) begin
        check("b2b_y", 32'(y), 32'(qy[res_n]));
        if (res_n > 0) check("b2b_spacing", 32'(cyc - last_t), 32'd6);
        last_t = cyc;
        res_n++;
      end
      busy_q = busy;
      ov_q   = out_valid;
    end
    check("b2b_count", 32'(res_n), 32'd3);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();

    // Asynchronous reset during the second RUN cycle.
    a = 8'h57;
    b = 8'h83;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    tick();
    tick();
    check("arst_hold_ov", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_post_ov", 32'(out_valid), 32'd0);
    run_op("after_rst", 8'h02, 8'h87, 8'h15, 0);

`ifdef GF_ABORT_EN
    // Abort during RUN: back to IDLE, no result, y keeps 02*87.
    a = 8'h57;
    b = 8'h83;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ov", 32'(out_valid), 32'd0);
    check("abort_y", 32'(y), 32'h15);
    check("abort_idle_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    tick();
    check("abort_no_accept", 32'(busy), 32'd0);
    abort = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_rdy_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_never_ov", 32'(out_valid), 32'd0);
    end
    check("abort_y_final", 32'(y), 32'h15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
